// File: rtl/parity_check_pipe_if.sv
// Valid/grant stream bundle for parity_check_pipe: producer-side inputs and
// consumer-side outputs, with the checker on the slave modport.
interface parity_check_pipe_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANES      = 4
);
  logic [DATA_WIDTH-1:0] data_i;
  logic [LANES-1:0]      parity_i;
  logic                  odd_i;
  logic                  valid_i;
  logic                  grant_o;
  logic                  valid_o;
  logic                  grant_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic [LANES-1:0]      err_o;

  modport slave (
    input  data_i, parity_i, odd_i, valid_i, grant_i,
    output grant_o, valid_o, data_o, err_o
  );

  modport master (
    output data_i, parity_i, odd_i, valid_i, grant_i,
    input  grant_o, valid_o, data_o, err_o
  );
endinterface

// File: rtl/parity_check_pipe.sv
// Multi-lane parity checker on a valid/grant stream with a two-entry skid buffer,
// saturating error-beat counter and sticky error flag.
module parity_check_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANES      = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned DROP_ERR   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  parity_check_pipe_if.slave   bus,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic                 err_sticky_o,
  input  logic                 clr_i
);

  localparam int unsigned LW = DATA_WIDTH / LANES;
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  if ((DATA_WIDTH % LANES) != 0) begin : g_bad_lanes
    $error("parity_check_pipe: DATA_WIDTH must be a multiple of LANES");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt
    $error("parity_check_pipe: CNT_WIDTH must be at least 1");
  end

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e                r_state, w_state_d;
  logic [DATA_WIDTH-1:0] r_main_data, r_skid_data, w_main_data_d, w_skid_data_d;
  logic [LANES-1:0]      r_main_err, r_skid_err, w_main_err_d, w_skid_err_d;
  logic [LANES-1:0]      w_err;
  logic                  w_any_err, w_accept, w_consume, w_store;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_sticky;

  always_comb begin
    w_err = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      w_err[k] = (^bus.data_i[k*LW +: LW]) ^ bus.parity_i[k] ^ bus.odd_i;
    end
  end

  assign w_any_err = |w_err;
  assign bus.grant_o = (r_state != StFull) & ~rst;
  assign bus.valid_o = (r_state != StEmpty);
  assign bus.data_o  = r_main_data;
  assign bus.err_o   = r_main_err;
  assign w_accept    = bus.valid_i & bus.grant_o;
  assign w_consume   = bus.valid_o & bus.grant_i;
  // In drop mode an errored beat is still accepted (and counted) but never stored.
  assign w_store     = w_accept & ~((DROP_ERR != 0) & w_any_err);

  always_comb begin
    w_state_d     = r_state;
    w_main_data_d = r_main_data;
    w_main_err_d  = r_main_err;
    w_skid_data_d = r_skid_data;
    w_skid_err_d  = r_skid_err;
    unique case (r_state)
      StEmpty: begin
        if (w_store) begin
          w_state_d     = StOne;
          w_main_data_d = bus.data_i;
          w_main_err_d  = w_err;
        end
      end
      StOne: begin
        if (w_store && w_consume) begin
          w_main_data_d = bus.data_i;
          w_main_err_d  = w_err;
        end else if (w_store) begin
          w_state_d     = StFull;
          w_skid_data_d = bus.data_i;
          w_skid_err_d  = w_err;
        end else if (w_consume) begin
          w_state_d = StEmpty;
        end
      end
      StFull: begin
        if (w_consume) begin
          w_state_d     = StOne;
          w_main_data_d = r_skid_data;
          w_main_err_d  = r_skid_err;
        end
      end
      default: w_state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StEmpty;
      r_main_data <= '0;
      r_main_err  <= '0;
      r_skid_data <= '0;
      r_skid_err  <= '0;
      r_cnt       <= '0;
      r_sticky    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_main_data <= w_main_data_d;
      r_main_err  <= w_main_err_d;
      r_skid_data <= w_skid_data_d;
      r_skid_err  <= w_skid_err_d;
      // Clear wins over a same-cycle error; that error is intentionally lost.
      if (clr_i) begin
        r_cnt    <= '0;
        r_sticky <= 1'b0;
      end else if (w_accept && w_any_err) begin
        r_sticky <= 1'b1;
        if (r_cnt != CntMax) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign err_cnt_o    = r_cnt;
  assign err_sticky_o = r_sticky;

endmodule

// File: tb/tb_parity_check_pipe.sv
// Directed bench for parity_check_pipe: default build, drop-on-error build and
// a 2-bit-counter build, each on its own interface instance.
module tb_parity_check_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_m = 1'b0, clr_d = 1'b0, clr_s = 1'b0;
  logic [15:0] cnt_m;
  logic [15:0] cnt_d;
  logic [1:0]  cnt_s;
  logic        sticky_m, sticky_d, sticky_s;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  parity_check_pipe_if #(.DATA_WIDTH(32), .LANES(4)) m ();
  parity_check_pipe_if #(.DATA_WIDTH(32), .LANES(4)) d ();
  parity_check_pipe_if #(.DATA_WIDTH(32), .LANES(4)) s ();

  parity_check_pipe #(.DATA_WIDTH(32), .LANES(4), .CNT_WIDTH(16), .DROP_ERR(0)) u_main (
    .clk(clk), .rst(rst), .bus(m), .err_cnt_o(cnt_m), .err_sticky_o(sticky_m), .clr_i(clr_m)
  );
  parity_check_pipe #(.DATA_WIDTH(32), .LANES(4), .CNT_WIDTH(16), .DROP_ERR(1)) u_drop (
    .clk(clk), .rst(rst), .bus(d), .err_cnt_o(cnt_d), .err_sticky_o(sticky_d), .clr_i(clr_d)
  );
  parity_check_pipe #(.DATA_WIDTH(32), .LANES(4), .CNT_WIDTH(2), .DROP_ERR(0)) u_sat (
    .clk(clk), .rst(rst), .bus(s), .err_cnt_o(cnt_s), .err_sticky_o(sticky_s), .clr_i(clr_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (m.valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", m.valid_o); end
    n_checks++; if (m.data_o !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h exp 0", m.data_o); end
    n_checks++; if (m.err_o !== 4'h0) begin n_fail++; $display("FAIL rst_err: got %h exp 0", m.err_o); end
    n_checks++; if (cnt_m !== 16'h0) begin n_fail++; $display("FAIL rst_cnt: got %h exp 0", cnt_m); end
    n_checks++; if (sticky_m !== 1'b0) begin n_fail++; $display("FAIL rst_sticky: got %b exp 0", sticky_m); end
    n_checks++; if (m.grant_o !== 1'b0) begin n_fail++; $display("FAIL rst_grant: got %b exp 0", m.grant_o); end
    rst = 1'b0;
    #1;
    n_checks++; if (m.grant_o !== 1'b1) begin n_fail++; $display("FAIL rst_release_grant: got %b exp 1", m.grant_o); end
  endtask

  task automatic test_clean();
    m.grant_i = 1'b1;
    m.data_i = 32'h0100_0000; m.parity_i = 4'b1000; m.odd_i = 1'b0; m.valid_i = 1'b1;
    step();
    m.valid_i = 1'b0;
    n_checks++; if (m.valid_o !== 1'b1) begin n_fail++; $display("FAIL clean_valid: got %b exp 1", m.valid_o); end
    n_checks++; if (m.data_o !== 32'h0100_0000) begin n_fail++; $display("FAIL clean_data: got %h exp 01000000", m.data_o); end
    n_checks++; if (m.err_o !== 4'h0) begin n_fail++; $display("FAIL clean_err: got %h exp 0", m.err_o); end
    n_checks++; if (cnt_m !== 16'h0) begin n_fail++; $display("FAIL clean_cnt: got %h exp 0", cnt_m); end
    step();
    n_checks++; if (m.valid_o !== 1'b0) begin n_fail++; $display("FAIL clean_drain: got %b exp 0", m.valid_o); end
  endtask

  task automatic test_lane_err();
    m.grant_i = 1'b1;
    m.data_i = 32'h0100_0000; m.parity_i = 4'b0000; m.odd_i = 1'b0; m.valid_i = 1'b1;
    step();
    n_checks++; if (m.err_o !== 4'b1000) begin n_fail++; $display("FAIL lane3_err: got %b exp 1000", m.err_o); end
    n_checks++; if (cnt_m !== 16'd1) begin n_fail++; $display("FAIL lane3_cnt: got %0d exp 1", cnt_m); end
    n_checks++; if (sticky_m !== 1'b1) begin n_fail++; $display("FAIL lane3_sticky: got %b exp 1", sticky_m); end
    m.parity_i = 4'b0111; m.odd_i = 1'b1;
    step();
    n_checks++; if (m.err_o !== 4'b0000) begin n_fail++; $display("FAIL odd_clean_err: got %b exp 0000", m.err_o); end
    n_checks++; if (cnt_m !== 16'd1) begin n_fail++; $display("FAIL odd_clean_cnt: got %0d exp 1", cnt_m); end
    m.data_i = 32'h0; m.parity_i = 4'b1111; m.odd_i = 1'b0;
    step();
    n_checks++; if (m.err_o !== 4'b1111) begin n_fail++; $display("FAIL all_lanes_err: got %b exp 1111", m.err_o); end
    n_checks++; if (cnt_m !== 16'd2) begin n_fail++; $display("FAIL all_lanes_cnt: got %0d exp 2", cnt_m); end
    m.valid_i = 1'b0;
    step();
    clr_m = 1'b1;
    step();
    clr_m = 1'b0;
    n_checks++; if (cnt_m !== 16'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d exp 0", cnt_m); end
    n_checks++; if (sticky_m !== 1'b0) begin n_fail++; $display("FAIL clr_sticky: got %b exp 0", sticky_m); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    m.grant_i = 1'b1; m.odd_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'hB0 + 8'(i);
      m.valid_i = 1'b1; m.data_i = {24'h0, b}; m.parity_i = {3'b000, ^b};
      n_checks++; if (m.grant_o !== 1'b1) begin n_fail++; $display("FAIL b2b_grant[%0d]: got %b exp 1", i, m.grant_o); end
      if (i > 0) begin
        n_checks++;
        if (m.valid_o !== 1'b1 || m.data_o !== {24'h0, 8'hB0 + 8'(i - 1)}) begin
          n_fail++; $display("FAIL b2b_data[%0d]: got v=%b %h exp v=1 %h", i, m.valid_o, m.data_o, 8'hB0 + 8'(i - 1));
        end
      end
      step();
    end
    m.valid_i = 1'b0;
    n_checks++; if (m.data_o !== 32'hB4 || m.err_o !== 4'h0) begin n_fail++; $display("FAIL b2b_last: got %h err %h exp b4 err 0", m.data_o, m.err_o); end
    step();
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int recv = 0;
    logic acc;
    logic [7:0] b;
    m.grant_i = 1'b0; m.odd_i = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      b = 8'hA0 + 8'(idx);
      m.valid_i = (idx < 5); m.data_i = {24'h0, b}; m.parity_i = {3'b000, ^b};
      if (cyc >= 1) begin
        n_checks++;
        if (m.valid_o !== 1'b1 || m.data_o !== 32'hA0) begin
          n_fail++; $display("FAIL bp_stall_hold[%0d]: got v=%b %h exp v=1 a0", cyc, m.valid_o, m.data_o);
        end
      end
      if (cyc >= 2) begin
        n_checks++; if (m.grant_o !== 1'b0) begin n_fail++; $display("FAIL bp_grant_full[%0d]: got %b exp 0", cyc, m.grant_o); end
      end
      acc = m.valid_i & m.grant_o;
      step();
      if (acc) idx++;
    end
    n_checks++; if (idx !== 2) begin n_fail++; $display("FAIL bp_accept_count: got %0d exp 2", idx); end
    m.grant_i = 1'b1;
    for (int cyc = 0; cyc < 20 && recv < 5; cyc++) begin
      b = 8'hA0 + 8'(idx);
      m.valid_i = (idx < 5); m.data_i = {24'h0, b}; m.parity_i = {3'b000, ^b};
      if (m.valid_o) begin
        n_checks++;
        if (m.data_o !== {24'h0, 8'hA0 + 8'(recv)}) begin
          n_fail++; $display("FAIL bp_order[%0d]: got %h exp %h", recv, m.data_o, 8'hA0 + 8'(recv));
        end
        recv++;
      end
      acc = m.valid_i & m.grant_o;
      step();
      if (acc) idx++;
    end
    m.valid_i = 1'b0;
    n_checks++; if (recv !== 5) begin n_fail++; $display("FAIL bp_recv_count: got %0d exp 5", recv); end
    n_checks++; if (m.valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got valid %b exp 0", m.valid_o); end
  endtask

  task automatic test_drop();
    logic [31:0] beats [3] = '{32'hC1, 32'hC2, 32'hC3};
    logic [3:0]  pars  [3] = '{4'b0001, 4'b0000, 4'b0000};
    logic [31:0] exp_q [2] = '{32'hC1, 32'hC3};
    int recv = 0;
    d.grant_i = 1'b1; d.odd_i = 1'b0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      d.valid_i = (cyc < 3);
      d.data_i = (cyc < 3) ? beats[cyc] : 32'h0;
      d.parity_i = (cyc < 3) ? pars[cyc] : 4'h0;
      if (cyc == 2) begin
        n_checks++; if (d.valid_o !== 1'b0) begin n_fail++; $display("FAIL drop_gap: got valid %b exp 0", d.valid_o); end
      end
      if (d.valid_o) begin
        n_checks++;
        if (recv >= 2) begin
          n_fail++; $display("FAIL drop_extra: got %h exp no beat", d.data_o);
        end else if (d.data_o !== exp_q[recv] || d.err_o !== 4'h0) begin
          n_fail++; $display("FAIL drop_data[%0d]: got %h err %h exp %h err 0", recv, d.data_o, d.err_o, exp_q[recv]);
        end
        recv++;
      end
      step();
    end
    d.valid_i = 1'b0;
    n_checks++; if (recv !== 2) begin n_fail++; $display("FAIL drop_recv: got %0d exp 2", recv); end
    n_checks++; if (cnt_d !== 16'd1) begin n_fail++; $display("FAIL drop_cnt: got %0d exp 1", cnt_d); end
    n_checks++; if (sticky_d !== 1'b1) begin n_fail++; $display("FAIL drop_sticky: got %b exp 1", sticky_d); end
  endtask

  task automatic test_sat_clear();
    logic [1:0] exp_cnt;
    s.grant_i = 1'b1; s.data_i = 32'h0; s.parity_i = 4'b0001; s.odd_i = 1'b0; s.valid_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      exp_cnt = (i < 3) ? 2'(i) : 2'd3;
      n_checks++; if (cnt_s !== exp_cnt) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d exp %0d", i, cnt_s, exp_cnt); end
    end
    n_checks++; if (s.err_o !== 4'b0001) begin n_fail++; $display("FAIL sat_err_mask: got %b exp 0001", s.err_o); end
    clr_s = 1'b1;
    step();
    clr_s = 1'b0;
    s.valid_i = 1'b0;
    n_checks++; if (cnt_s !== 2'd0) begin n_fail++; $display("FAIL clr_vs_err_cnt: got %0d exp 0", cnt_s); end
    n_checks++; if (sticky_s !== 1'b0) begin n_fail++; $display("FAIL clr_vs_err_sticky: got %b exp 0", sticky_s); end
    step();
    n_checks++; if (cnt_s !== 2'd0) begin n_fail++; $display("FAIL clr_hold_cnt: got %0d exp 0", cnt_s); end
  endtask

  task automatic test_reset_full();
    m.grant_i = 1'b0; m.odd_i = 1'b0; m.parity_i = 4'h0; m.valid_i = 1'b1;
    m.data_i = 32'hD0;
    step();
    m.data_i = 32'hD1;
    step();
    m.data_i = 32'hD2;
    n_checks++; if (m.grant_o !== 1'b0 || m.valid_o !== 1'b1) begin n_fail++; $display("FAIL rf_full: got grant %b valid %b exp 0 1", m.grant_o, m.valid_o); end
    rst = 1'b1;
    #1;
    n_checks++; if (m.grant_o !== 1'b0) begin n_fail++; $display("FAIL rf_grant_in_rst: got %b exp 0", m.grant_o); end
    step();
    n_checks++; if (m.valid_o !== 1'b0 || m.data_o !== 32'h0) begin n_fail++; $display("FAIL rf_rst_out: got v=%b %h exp v=0 0", m.valid_o, m.data_o); end
    rst = 1'b0; m.valid_i = 1'b0; m.grant_i = 1'b1;
    #1;
    n_checks++; if (m.grant_o !== 1'b1) begin n_fail++; $display("FAIL rf_grant_release: got %b exp 1", m.grant_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (m.valid_o !== 1'b0) begin n_fail++; $display("FAIL rf_stale[%0d]: got valid %b data %h exp 0", i, m.valid_o, m.data_o); end
    end
    m.valid_i = 1'b1; m.data_i = 32'hE0; m.parity_i = 4'b0001;
    step();
    m.valid_i = 1'b0;
    n_checks++; if (m.valid_o !== 1'b1 || m.data_o !== 32'hE0) begin n_fail++; $display("FAIL rf_fresh: got v=%b %h exp v=1 e0", m.valid_o, m.data_o); end
    step();
  endtask

  initial begin
    m.data_i = '0; m.parity_i = '0; m.odd_i = 1'b0; m.valid_i = 1'b0; m.grant_i = 1'b0;
    d.data_i = '0; d.parity_i = '0; d.odd_i = 1'b0; d.valid_i = 1'b0; d.grant_i = 1'b0;
    s.data_i = '0; s.parity_i = '0; s.odd_i = 1'b0; s.valid_i = 1'b0; s.grant_i = 1'b0;
    test_reset();
    test_clean();
    test_lane_err();
    test_back_to_back();
    test_backpressure();
    test_drop();
    test_sat_clear();
    test_reset_full();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
